// File: rtl/riscv_pc_pkg.sv
// ============================================================================
// riscv_pc_pkg : shared constants and state encoding for the fetch PC logic
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_pc_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP_DEFAULT  = 32'd4;
  localparam logic [XLEN-1:0] ALIGN_MASK       = 32'hFFFF_FFFC;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } pc_state_e;
endpackage

`default_nettype wire

// File: rtl/pc_redirect_hold.sv
// ============================================================================
// pc_redirect_hold : captures a redirect target raised during a fetch stall
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_redirect_hold
  import riscv_pc_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET,
  input  logic            capture_i,
  input  logic            release_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] held_target_o,
  output logic            redirect_pending_o
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] target_q, target_d;

  // Only the first target is captured; the EX stage is frozen while stalled.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    case (state_q)
      RUN: begin
        if (capture_i) begin
          state_d  = HOLD;
          target_d = target_i;
        end
      end
      HOLD: begin
        if (release_i) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= RUN;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  assign held_target_o      = target_q;
  assign redirect_pending_o = (state_q == HOLD);

endmodule

`default_nettype wire

// File: rtl/pc_update_unit.sv
// ============================================================================
// pc_update_unit : fetch-stage PC register, sequential increment, redirects
// and IF/ID, ID/EX flush pulses. Optional macro: PC_MISALIGN_CHECK_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_update_unit
  import riscv_pc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            busywait,
  input  logic            branch_jump_mux_signal,
  input  logic [XLEN-1:0] Branch_jump_PC_OUT,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_PLUS_4,
  output logic            redirect_pending,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            misaligned_fault
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] held_target;
  logic [XLEN-1:0] target_sel;
  logic            pending;
  logic            accept;
  logic            flush_q, flush_d;
  logic            fault_d;

  pc_redirect_hold u_hold (
    .CLK                (CLK),
    .RESET              (RESET),
    .capture_i          (busywait & branch_jump_mux_signal),
    .release_i          (~busywait),
    .target_i           (Branch_jump_PC_OUT),
    .held_target_o      (held_target),
    .redirect_pending_o (pending)
  );

  assign PC_PLUS_4 = pc_q + PC_STEP;

  // A held target takes priority over any new request on the release cycle.
  assign accept     = ~busywait & (pending | branch_jump_mux_signal);
  assign target_sel = pending ? held_target : Branch_jump_PC_OUT;

  always_comb begin
    pc_d    = pc_q;
    flush_d = 1'b0;
    fault_d = 1'b0;
    if (!busywait) begin
      if (accept) begin
`ifdef PC_MISALIGN_CHECK_EN
        if (target_sel[1:0] != 2'b00) begin
          pc_d    = PC_PLUS_4;
          fault_d = 1'b1;
        end else begin
          pc_d    = target_sel;
          flush_d = 1'b1;
        end
`else
        pc_d    = target_sel & ALIGN_MASK;
        flush_d = 1'b1;
`endif
      end else begin
        pc_d = PC_PLUS_4;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      flush_q <= flush_d;
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  logic fault_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign misaligned_fault = fault_q;
`else
  logic unused_fault;
  assign unused_fault     = fault_d;
  assign misaligned_fault = 1'b0;
`endif

  assign PC               = pc_q;
  assign redirect_pending = pending;
  assign flush_if_id      = flush_q;
  assign flush_id_ex      = flush_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_update_unit.sv
// ============================================================================
// tb_pc_update_unit : directed and randomized bench for pc_update_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_update_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        busywait = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic [31:0] PC, PC_PLUS_4;
  logic        redirect_pending, flush_if_id, flush_id_ex, misaligned_fault;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_held = 32'h0;
  bit          m_pend = 1'b0;
  bit          m_flush = 1'b0;
  bit          m_fault = 1'b0;

  pc_update_unit dut (
    .CLK                    (CLK),
    .RESET                  (RESET),
    .busywait               (busywait),
    .branch_jump_mux_signal (redir),
    .Branch_jump_PC_OUT     (tgt),
    .PC                     (PC),
    .PC_PLUS_4              (PC_PLUS_4),
    .redirect_pending       (redirect_pending),
    .flush_if_id            (flush_if_id),
    .flush_id_ex            (flush_id_ex),
    .misaligned_fault       (misaligned_fault)
  );

  always #5 CLK = ~CLK;

  task automatic drive(input bit r, input bit b, input bit rd, input logic [31:0] t);
    RESET = r; busywait = b; redir = rd; tgt = t;
  endtask

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic tick();
    logic [31:0] t;
    @(posedge CLK);
    #1;
    if (RESET) begin
      m_pc = 32'h0; m_pend = 0; m_held = 32'h0; m_flush = 0; m_fault = 0;
    end else begin
      m_flush = 0; m_fault = 0;
      if (busywait) begin
        if (redir && !m_pend) begin m_pend = 1; m_held = tgt; end
      end else if (m_pend || redir) begin
        t = m_pend ? m_held : tgt;
        m_pend = 0;
`ifdef PC_MISALIGN_CHECK_EN
        if (t % 4 != 0) begin m_pc = m_pc + 4; m_fault = 1; end
        else begin m_pc = t; m_flush = 1; end
`else
        m_pc = t - (t % 4);
        m_flush = 1;
`endif
      end else begin
        m_pc = m_pc + 4;
      end
    end
  endtask

  task automatic goto_pc(input logic [31:0] v);
    drive(0, 0, 1, v - 32'd4); tick();
    drive(0, 0, 0, 32'h0);     tick();
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc [6] = '{32'h0, 32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    drive(1, 0, 0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) drive(0, 0, 0, 32'h0);
      tick();
      vectors++;
      if (PC !== exp_pc[i]) begin
        miscompares++; $display("FAIL reset_seq[%0d]: PC=%h expected %h", i, PC, exp_pc[i]);
      end
      vectors++;
      if ({flush_if_id, flush_id_ex, redirect_pending} !== 3'b000) begin
        miscompares++; $display("FAIL reset_flags[%0d]: got %b expected 000", i, {flush_if_id, flush_id_ex, redirect_pending});
      end
    end
  endtask

  task automatic test_redirect();
    goto_pc(32'h20);
    drive(0, 0, 1, 32'h100); tick();
    vectors++;
    if (PC !== 32'h100) begin miscompares++; $display("FAIL redirect_pc: PC=%h expected 00000100", PC); end
    vectors++;
    if ({flush_if_id, flush_id_ex} !== 2'b11) begin
      miscompares++; $display("FAIL redirect_flush: got %b expected 11", {flush_if_id, flush_id_ex});
    end
    drive(0, 0, 0, 32'h0); tick();
    vectors++;
    if ({flush_if_id, flush_id_ex} !== 2'b00 || PC !== 32'h104) begin
      miscompares++; $display("FAIL redirect_after: flush=%b PC=%h expected 00, 00000104", {flush_if_id, flush_id_ex}, PC);
    end
  endtask

  task automatic test_stall_hold();
    goto_pc(32'h40);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, (i < 2), (i == 0) ? 32'h200 : 32'h300);
      tick();
      vectors++;
      if (PC !== 32'h40 || redirect_pending !== 1'b1 || flush_if_id !== 1'b0) begin
        miscompares++; $display("FAIL stall[%0d]: PC=%h pend=%b flush=%b expected 00000040,1,0", i, PC, redirect_pending, flush_if_id);
      end
    end
    drive(0, 0, 0, 32'h0); tick();
    vectors++;
    if (PC !== 32'h200 || redirect_pending !== 1'b0 || flush_id_ex !== 1'b1) begin
      miscompares++; $display("FAIL stall_release: PC=%h pend=%b flush=%b expected 00000200,0,1", PC, redirect_pending, flush_id_ex);
    end
    tick();
    vectors++;
    if (PC !== 32'h204 || flush_if_id !== 1'b0) begin
      miscompares++; $display("FAIL stall_after: PC=%h flush=%b expected 00000204,0", PC, flush_if_id);
    end
  endtask

  task automatic test_reset_in_hold();
    goto_pc(32'h40);
    drive(0, 1, 1, 32'h200); tick();
    vectors++;
    if (redirect_pending !== 1'b1) begin miscompares++; $display("FAIL hold_entry: pend=%b expected 1", redirect_pending); end
    drive(1, 1, 0, 32'h0); tick();
    vectors++;
    if (PC !== 32'h0 || redirect_pending !== 1'b0 || flush_if_id !== 1'b0) begin
      miscompares++; $display("FAIL hold_reset: PC=%h pend=%b flush=%b expected 00000000,0,0", PC, redirect_pending, flush_if_id);
    end
    drive(0, 0, 0, 32'h0); tick();
    vectors++;
    if (PC !== 32'h4 || flush_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin
      miscompares++; $display("FAIL hold_reset_after: PC=%h flush=%b expected 00000004,00", PC, {flush_if_id, flush_id_ex});
    end
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    vectors++;
    if (PC_PLUS_4 !== 32'h0) begin miscompares++; $display("FAIL wrap_plus4: PC_PLUS_4=%h expected 00000000", PC_PLUS_4); end
    tick();
    vectors++;
    if (PC !== 32'h0 || misaligned_fault !== 1'b0 || flush_if_id !== 1'b0) begin
      miscompares++; $display("FAIL wrap_pc: PC=%h fault=%b flush=%b expected 00000000,0,0", PC, misaligned_fault, flush_if_id);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_pc;
    bit exp_fault, exp_flush;
`ifdef PC_MISALIGN_CHECK_EN
    exp_pc = 32'h84; exp_fault = 1; exp_flush = 0;
`else
    exp_pc = 32'h100; exp_fault = 0; exp_flush = 1;
`endif
    for (int pass = 0; pass < 2; pass++) begin
      goto_pc(32'h80);
      if (pass == 1) begin
        drive(0, 1, 1, 32'h102); tick();
        drive(0, 0, 0, 32'h0);   tick();
      end else begin
        drive(0, 0, 1, 32'h102); tick();
      end
      vectors++;
      if (PC !== exp_pc || misaligned_fault !== exp_fault || flush_if_id !== exp_flush) begin
        miscompares++;
        $display("FAIL misalign[%0d]: PC=%h fault=%b flush=%b expected %h,%b,%b", pass, PC, misaligned_fault, flush_if_id, exp_pc, exp_fault, exp_flush);
      end
      drive(0, 0, 0, 32'h0); tick();
      vectors++;
      if (misaligned_fault !== 1'b0 || flush_if_id !== 1'b0) begin
        miscompares++; $display("FAIL misalign_after[%0d]: fault=%b flush=%b expected 0,0", pass, misaligned_fault, flush_if_id);
      end
    end
  endtask

  task automatic test_back_to_back();
    goto_pc(32'h0);
    drive(0, 0, 1, 32'h300); tick();
    vectors++;
    if (PC !== 32'h300 || flush_if_id !== 1'b1) begin
      miscompares++; $display("FAIL b2b_first: PC=%h flush=%b expected 00000300,1", PC, flush_if_id);
    end
    drive(0, 0, 1, 32'h500); tick();
    vectors++;
    if (PC !== 32'h500 || flush_id_ex !== 1'b1) begin
      miscompares++; $display("FAIL b2b_second: PC=%h flush=%b expected 00000500,1", PC, flush_id_ex);
    end
    drive(0, 0, 0, 32'h0); tick();
    vectors++;
    if (flush_if_id !== 1'b0) begin miscompares++; $display("FAIL b2b_end: flush=%b expected 0", flush_if_id); end
  endtask

  task automatic test_random();
    logic [31:0] t;
    for (int i = 0; i < 600; i++) begin
      t = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3, t);
      tick();
      vectors++;
      if (PC !== m_pc) begin miscompares++; $display("FAIL rand_pc[%0d]: PC=%h expected %h", i, PC, m_pc); end
      vectors++;
      if (PC_PLUS_4 !== m_pc + 32'd4) begin
        miscompares++; $display("FAIL rand_plus4[%0d]: PC_PLUS_4=%h expected %h", i, PC_PLUS_4, m_pc + 32'd4);
      end
      vectors++;
      if (redirect_pending !== m_pend) begin
        miscompares++; $display("FAIL rand_pend[%0d]: pend=%b expected %b", i, redirect_pending, m_pend);
      end
      vectors++;
      if (flush_if_id !== m_flush || flush_id_ex !== m_flush) begin
        miscompares++; $display("FAIL rand_flush[%0d]: flush=%b expected %b", i, {flush_if_id, flush_id_ex}, {m_flush, m_flush});
      end
      vectors++;
      if (misaligned_fault !== m_fault) begin
        miscompares++; $display("FAIL rand_fault[%0d]: fault=%b expected %b", i, misaligned_fault, m_fault);
      end
    end
  endtask

  initial begin
    test_reset();
    test_redirect();
    test_stall_hold();
    test_reset_in_hold();
    test_wrap();
    test_misalign();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
